// File: rtl/register_bank_mp_pkg.sv
// Shared constants for the multi-port register bank: default geometry and the
// helper used to locate a read port's slice in the flattened read buses.
package register_bank_mp_pkg;

    localparam int unsigned DefAddressSize  = 5;
    localparam int unsigned DefRegisterSize = 32;
    localparam int unsigned DefReadPorts    = 2;
    localparam int unsigned MaxReadPorts    = 4;

    // LSB of read port `port` inside a bus packed `width` bits per port.
    function automatic int unsigned rd_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/register_bank_mp_if.sv
// Bundle of write ports, scoreboard set and flattened read ports of the register bank.
interface register_bank_mp_if
    import register_bank_mp_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE  = DefAddressSize,
    parameter int unsigned REGISTER_SIZE = DefRegisterSize,
    parameter int unsigned READ_PORTS    = DefReadPorts
);

    logic                                 wr0_en;
    logic [ADDRESS_SIZE-1:0]              wr0_addr;
    logic [REGISTER_SIZE-1:0]             wr0_data;
    logic                                 wr1_en;
    logic [ADDRESS_SIZE-1:0]              wr1_addr;
    logic [REGISTER_SIZE-1:0]             wr1_data;
    logic                                 sb_set;
    logic [ADDRESS_SIZE-1:0]              sb_addr;
    logic [READ_PORTS*ADDRESS_SIZE-1:0]   rd_addr;
    logic [READ_PORTS*REGISTER_SIZE-1:0]  rd_data;
    logic [READ_PORTS-1:0]                rd_pending;

    modport master (
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output sb_set, sb_addr,
        output rd_addr,
        input  rd_data, rd_pending
    );

    modport slave (
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  sb_set, sb_addr,
        input  rd_addr,
        output rd_data, rd_pending
    );

endinterface

// File: rtl/rb_read_port.sv
// One combinational read port: array lookup, optional write forwarding and
// pending-bit lookup with the same-cycle write/set interaction applied.
module rb_read_port
    import register_bank_mp_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE  = DefAddressSize,
    parameter int unsigned REGISTER_SIZE = DefRegisterSize,
    parameter int unsigned DEPTH         = 1 << DefAddressSize,
    parameter bit          ZERO_REG      = 1'b1,
    parameter bit          BYPASS        = 1'b1
) (
    input  logic [ADDRESS_SIZE-1:0]              addr,
    input  logic [DEPTH-1:0][REGISTER_SIZE-1:0]  regs,
    input  logic [DEPTH-1:0]                     pend,
    input  logic                                 wr0_act,
    input  logic [ADDRESS_SIZE-1:0]              wr0_addr,
    input  logic [REGISTER_SIZE-1:0]             wr0_data,
    input  logic                                 wr1_act,
    input  logic [ADDRESS_SIZE-1:0]              wr1_addr,
    input  logic [REGISTER_SIZE-1:0]             wr1_data,
    input  logic                                 sb_act,
    input  logic [ADDRESS_SIZE-1:0]              sb_addr,
    output logic [REGISTER_SIZE-1:0]             data,
    output logic                                 pending
);

    logic hit0, hit1, sb_hit;

    always_comb begin
        hit0    = BYPASS && wr0_act && (wr0_addr == addr);
        hit1    = BYPASS && wr1_act && (wr1_addr == addr);
        sb_hit  = sb_act && (sb_addr == addr);
        data    = regs[addr];
        pending = pend[addr];
        if (hit0) begin
            data = wr0_data;
        end else if (hit1) begin
            data = wr1_data;
        end
        // A retiring write hides the pending bit unless a new producer is issued alongside.
        if ((hit0 || hit1) && !sb_hit) begin
            pending = 1'b0;
        end
        if (ZERO_REG && (addr == '0)) begin
            data    = '0;
            pending = 1'b0;
        end
    end

endmodule

// File: rtl/register_bank_mp.sv
// Multi-port register bank with two prioritised write ports, a per-register
// pending scoreboard and READ_PORTS combinational read ports.
module register_bank_mp
    import register_bank_mp_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE  = DefAddressSize,
    parameter int unsigned REGISTER_SIZE = DefRegisterSize,
    parameter int unsigned READ_PORTS    = DefReadPorts,
    parameter bit          ZERO_REG      = 1'b1,
    parameter bit          BYPASS        = 1'b1
) (
    input logic               clk,
    input logic               reset,
    register_bank_mp_if.slave bus
);

    localparam int unsigned Depth = 1 << ADDRESS_SIZE;

    logic [Depth-1:0][REGISTER_SIZE-1:0] regs_q, regs_d;
    logic [Depth-1:0]                    pend_q, pend_d;
    logic                                wr0_act, wr1_act, sb_act;

    // Gating with reset keeps writes and forwarding inert while the bank is held clear.
    always_comb begin
        wr0_act = reset && bus.wr0_en && !(ZERO_REG && (bus.wr0_addr == '0));
        wr1_act = reset && bus.wr1_en && !(ZERO_REG && (bus.wr1_addr == '0));
        sb_act  = reset && bus.sb_set && !(ZERO_REG && (bus.sb_addr == '0));
    end

    // wr0 is applied after wr1 so it wins a same-address collision; sb_set is last.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr1_act) begin
            regs_d[bus.wr1_addr] = bus.wr1_data;
            pend_d[bus.wr1_addr] = 1'b0;
        end
        if (wr0_act) begin
            regs_d[bus.wr0_addr] = bus.wr0_data;
            pend_d[bus.wr0_addr] = 1'b0;
        end
        if (sb_act) begin
            pend_d[bus.sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_read_port
        rb_read_port #(
            .ADDRESS_SIZE  (ADDRESS_SIZE),
            .REGISTER_SIZE (REGISTER_SIZE),
            .DEPTH         (Depth),
            .ZERO_REG      (ZERO_REG),
            .BYPASS        (BYPASS)
        ) u_read_port (
            .addr     (bus.rd_addr[rd_lsb(k, ADDRESS_SIZE) +: ADDRESS_SIZE]),
            .regs     (regs_q),
            .pend     (pend_q),
            .wr0_act  (wr0_act),
            .wr0_addr (bus.wr0_addr),
            .wr0_data (bus.wr0_data),
            .wr1_act  (wr1_act),
            .wr1_addr (bus.wr1_addr),
            .wr1_data (bus.wr1_data),
            .sb_act   (sb_act),
            .sb_addr  (bus.sb_addr),
            .data     (bus.rd_data[rd_lsb(k, REGISTER_SIZE) +: REGISTER_SIZE]),
            .pending  (bus.rd_pending[k])
        );
    end

endmodule

// File: tb/tb_register_bank_mp.sv
// Scoreboard bench: the stimulus pushes expected read results, a negedge
// monitor pops and compares them against three differently configured banks.
module tb_register_bank_mp;

    logic clk;
    logic reset;

    typedef struct {
        string       name;
        int          dut;
        int          port;
        logic [31:0] data;
        logic        pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    logic [7:0] tbl [8] = '{8'h3C, 8'hA1, 8'h5E, 8'h07, 8'hF0, 8'h69, 8'h92, 8'hDB};

    register_bank_mp_if #(.ADDRESS_SIZE(5), .REGISTER_SIZE(32), .READ_PORTS(2)) bus0 ();
    register_bank_mp_if #(.ADDRESS_SIZE(3), .REGISTER_SIZE(8),  .READ_PORTS(1)) bus1 ();
    register_bank_mp_if #(.ADDRESS_SIZE(3), .REGISTER_SIZE(8),  .READ_PORTS(4)) bus2 ();

    register_bank_mp #(
        .ADDRESS_SIZE(5), .REGISTER_SIZE(32), .READ_PORTS(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

    register_bank_mp #(
        .ADDRESS_SIZE(3), .REGISTER_SIZE(8), .READ_PORTS(1), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    register_bank_mp #(
        .ADDRESS_SIZE(3), .REGISTER_SIZE(8), .READ_PORTS(4), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void get_actual(input int dut, input int port,
                                       output logic [31:0] d, output logic p);
        d = 'x;
        p = 1'bx;
        case (dut)
            0: begin
                d = bus0.rd_data[port*32 +: 32];
                p = bus0.rd_pending[port];
            end
            1: begin
                d = 32'(bus1.rd_data[7:0]);
                p = bus1.rd_pending[0];
            end
            default: begin
                d = 32'(bus2.rd_data[port*8 +: 8]);
                p = bus2.rd_pending[port];
            end
        endcase
    endfunction

    // Monitor: read ports are combinational, so results are valid mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            exp_t        e;
            logic [31:0] ad;
            logic        ap;
            e = exp_q.pop_front();
            get_actual(e.dut, e.port, ad, ap);
            n_checks++;
            if (ad !== e.data || ap !== e.pend) begin
                n_fail++;
                $display("FAIL %s dut%0d port%0d: got data=%h pend=%b, want data=%h pend=%b",
                         e.name, e.dut, e.port, ad, ap, e.data, e.pend);
            end
        end
    end

    task automatic expect_rd(input string name, input int dut, input int port,
                             input logic [31:0] data, input logic pend);
        exp_t e;
        e.name = name;
        e.dut  = dut;
        e.port = port;
        e.data = data;
        e.pend = pend;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus0.wr0_en = 1'b0; bus0.wr1_en = 1'b0; bus0.sb_set = 1'b0;
        bus1.wr0_en = 1'b0; bus1.wr1_en = 1'b0; bus1.sb_set = 1'b0;
        bus2.wr0_en = 1'b0; bus2.wr1_en = 1'b0; bus2.sb_set = 1'b0;
    endtask

    task automatic rd0(input logic [4:0] a0, input logic [4:0] a1);
        bus0.rd_addr = {a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus0.wr0_addr = '0; bus0.wr0_data = '0; bus0.wr1_addr = '0; bus0.wr1_data = '0;
        bus0.sb_addr  = '0; bus0.rd_addr  = '0;
        bus1.wr0_addr = '0; bus1.wr0_data = '0; bus1.wr1_addr = '0; bus1.wr1_data = '0;
        bus1.sb_addr  = '0; bus1.rd_addr  = '0;
        bus2.wr0_addr = '0; bus2.wr0_data = '0; bus2.wr1_addr = '0; bus2.wr1_data = '0;
        bus2.sb_addr  = '0; bus2.rd_addr  = '0;
        idle();
        tick();
        tick();
        reset = 1'b1;

        // Write then read, with same-cycle forwarding
        tick(); idle();
        bus0.wr0_en = 1'b1; bus0.wr0_addr = 5'd3; bus0.wr0_data = 32'hA5A5_A5A5;
        rd0(5'd3, 5'd3);
        expect_rd("wr_bypass", 0, 0, 32'hA5A5_A5A5, 1'b0);
        expect_rd("wr_bypass", 0, 1, 32'hA5A5_A5A5, 1'b0);
        tick(); idle();
        rd0(5'd3, 5'd7);
        expect_rd("wr_readback", 0, 0, 32'hA5A5_A5A5, 1'b0);
        expect_rd("unwritten", 0, 1, 32'h0, 1'b0);

        // Port collision: wr0 wins in storage and forwarding
        tick(); idle();
        bus0.wr0_en = 1'b1; bus0.wr0_addr = 5'd7; bus0.wr0_data = 32'h11;
        bus0.wr1_en = 1'b1; bus0.wr1_addr = 5'd7; bus0.wr1_data = 32'h22;
        rd0(5'd7, 5'd7);
        expect_rd("collide_bypass", 0, 0, 32'h11, 1'b0);
        expect_rd("collide_bypass", 0, 1, 32'h11, 1'b0);
        tick(); idle();
        expect_rd("collide_store", 0, 0, 32'h11, 1'b0);
        expect_rd("collide_store", 0, 1, 32'h11, 1'b0);

        // Zero register
        tick(); idle();
        bus0.wr0_en = 1'b1; bus0.wr0_addr = 5'd0; bus0.wr0_data = 32'hFFFF_FFFF;
        bus0.sb_set = 1'b1; bus0.sb_addr  = 5'd0;
        rd0(5'd0, 5'd0);
        expect_rd("zero_wcycle", 0, 0, 32'h0, 1'b0);
        expect_rd("zero_wcycle", 0, 1, 32'h0, 1'b0);
        tick(); idle();
        expect_rd("zero_after", 0, 0, 32'h0, 1'b0);
        expect_rd("zero_after", 0, 1, 32'h0, 1'b0);

        // Scoreboard set, clear by wr1, set-wins against wr0
        tick(); idle();
        bus0.sb_set = 1'b1; bus0.sb_addr = 5'd5;
        rd0(5'd5, 5'd3);
        expect_rd("sb_set_cycle", 0, 0, 32'h0, 1'b0);
        tick(); idle();
        rd0(5'd5, 5'd5);
        expect_rd("sb_pending", 0, 0, 32'h0, 1'b1);
        expect_rd("sb_pending", 0, 1, 32'h0, 1'b1);
        tick(); idle();
        bus0.wr1_en = 1'b1; bus0.wr1_addr = 5'd5; bus0.wr1_data = 32'h55;
        expect_rd("sb_clear_bypass", 0, 0, 32'h55, 1'b0);
        tick(); idle();
        expect_rd("sb_cleared", 0, 0, 32'h55, 1'b0);
        tick(); idle();
        bus0.sb_set = 1'b1; bus0.sb_addr  = 5'd9;
        bus0.wr0_en = 1'b1; bus0.wr0_addr = 5'd9; bus0.wr0_data = 32'h99;
        rd0(5'd9, 5'd9);
        expect_rd("sb_vs_wr_cycle", 0, 0, 32'h99, 1'b0);
        tick(); idle();
        expect_rd("sb_set_wins", 0, 0, 32'h99, 1'b1);
        expect_rd("sb_set_wins", 0, 1, 32'h99, 1'b1);

        // Both write ports to different addresses
        tick(); idle();
        bus0.wr0_en = 1'b1; bus0.wr0_addr = 5'd10; bus0.wr0_data = 32'h0000_000A;
        bus0.wr1_en = 1'b1; bus0.wr1_addr = 5'd11; bus0.wr1_data = 32'h0000_000B;
        rd0(5'd10, 5'd11);
        expect_rd("dual_bypass0", 0, 0, 32'hA, 1'b0);
        expect_rd("dual_bypass1", 0, 1, 32'hB, 1'b0);
        tick(); idle();
        expect_rd("dual_store0", 0, 0, 32'hA, 1'b0);
        expect_rd("dual_store1", 0, 1, 32'hB, 1'b0);

        // Mid-operation reset; writes and sb_set during reset must not take effect
        for (int a = 0; a < 32; a++) begin
            tick(); idle();
            reset = 1'b0;
            bus0.wr0_en = 1'b1; bus0.wr0_addr = 5'(a); bus0.wr0_data = 32'hDEAD_0000 | 32'(a);
            bus0.sb_set = 1'b1; bus0.sb_addr  = 5'(a);
            rd0(5'(a), 5'(31 - a));
            expect_rd("in_reset", 0, 0, 32'h0, 1'b0);
            expect_rd("in_reset", 0, 1, 32'h0, 1'b0);
        end
        tick(); idle();
        reset = 1'b1;
        rd0(5'd3, 5'd31);
        expect_rd("post_reset", 0, 0, 32'h0, 1'b0);
        expect_rd("post_reset", 0, 1, 32'h0, 1'b0);
        tick(); idle();
        rd0(5'd9, 5'd5);
        expect_rd("post_reset_pend", 0, 0, 32'h0, 1'b0);
        expect_rd("post_reset_pend", 0, 1, 32'h0, 1'b0);

        // Parameter sweep: no forwarding, all registers on every port
        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            tick(); idle();
            v = ~tbl[i];
            bus1.wr0_en = 1'b1; bus1.wr0_addr = 3'(i); bus1.wr0_data = tbl[i];
            if (i % 2 == 1) begin
                bus2.wr1_en = 1'b1; bus2.wr1_addr = 3'(i); bus2.wr1_data = v;
            end else begin
                bus2.wr0_en = 1'b1; bus2.wr0_addr = 3'(i); bus2.wr0_data = v;
            end
            bus1.rd_addr = 3'(i);
            bus2.rd_addr = {4{3'(i)}};
            expect_rd("sweep_no_fwd", 1, 0, 32'h0, 1'b0);
            for (int k = 0; k < 4; k++) expect_rd("sweep_no_fwd", 2, k, 32'h0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            tick(); idle();
            bus1.rd_addr = 3'(i);
            expect_rd("sweep_rd1", 1, 0, 32'(tbl[i]), 1'b0);
            for (int k = 0; k < 4; k++) begin
                logic [7:0] v;
                int         j;
                j = (i + k) % 8;
                v = ~tbl[j];
                bus2.rd_addr[k*3 +: 3] = 3'(j);
                expect_rd("sweep_rd4", 2, k, 32'(v), 1'b0);
            end
        end
        tick(); idle();
        bus1.wr0_en = 1'b1; bus1.wr0_addr = 3'd2; bus1.wr0_data = 8'h44;
        bus1.rd_addr = 3'd2;
        expect_rd("sweep_old_data", 1, 0, 32'(tbl[2]), 1'b0);
        tick(); idle();
        expect_rd("sweep_new_data", 1, 0, 32'h44, 1'b0);

        tick(); idle();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
